// File: rtl/signed_accum_with_overflow.sv
// signed_accum_with_overflow
// Streaming two's-complement accumulator with per-step signed overflow
// detection, a sticky overflow flag and a saturating overflow event counter.
// All outputs are registered; latency from arg to res is one cycle.
//
// Optional feature: define SIGNED_ACCUM_SATURATE_EN to clamp the accumulator
// to the most positive / most negative value on overflow instead of wrapping.
// Without the macro the accumulator wraps around (truncated sum).

module signed_accum_with_overflow #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    input  logic [WIDTH-1:0] arg,
    input  logic             clear,
    output logic             res_vld,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             overflow_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base_acc;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] next_acc;
    logic             step_ovf;
    logic             cnt_full;

    // A clear restarts the step from zero, so a clear with a valid arg
    // loads arg directly and can never overflow.
    always_comb begin
        base_acc = clear ? '0 : acc;
        raw_sum  = base_acc + arg;
        step_ovf = (base_acc[WIDTH-1] == arg[WIDTH-1]) &&
                   (raw_sum[WIDTH-1] != base_acc[WIDTH-1]);
        cnt_full = (ovf_count == {CNT_W{1'b1}});
`ifdef SIGNED_ACCUM_SATURATE_EN
        // Overflow direction follows the common operand sign.
        if (step_ovf) begin
            next_acc = base_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            next_acc = raw_sum;
        end
`else
        next_acc = raw_sum;
`endif
    end

    // Accumulator, result strobe and overflow bookkeeping; reset wins over
    // everything and discards any step presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc             <= '0;
            res_vld         <= 1'b0;
            overflow        <= 1'b0;
            overflow_sticky <= 1'b0;
            ovf_count       <= '0;
        end else begin
            res_vld  <= arg_vld;
            overflow <= arg_vld && step_ovf;
            if (clear) begin
                overflow_sticky <= 1'b0;
                ovf_count       <= '0;
                acc             <= arg_vld ? next_acc : '0;
            end else if (arg_vld) begin
                acc <= next_acc;
                if (step_ovf) begin
                    overflow_sticky <= 1'b1;
                    if (!cnt_full) begin
                        ovf_count <= ovf_count + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign res = acc;

endmodule

// File: tb/tb_signed_accum_with_overflow.sv
// tb_signed_accum_with_overflow
// Directed scenarios followed by random streams, compared cycle by cycle
// against an integer-arithmetic reference model of the accumulator.
// Honours SIGNED_ACCUM_SATURATE_EN the same way the design does.

module tb_signed_accum_with_overflow;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam int HALF  = 2 ** (WIDTH - 1);
    localparam int CMAX  = 2 ** CNT_W - 1;

    logic             clk;
    logic             rst;
    logic             arg_vld;
    logic [WIDTH-1:0] arg;
    logic             clear;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic             overflow;
    logic             overflow_sticky;
    logic [CNT_W-1:0] ovf_count;

    int num_vectors = 0;
    int num_miscompares = 0;

    int m_acc = 0;
    int m_vld = 0;
    int m_ovf = 0;
    int m_sticky = 0;
    int m_cnt = 0;

    signed_accum_with_overflow #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .arg_vld(arg_vld),
        .arg(arg),
        .clear(clear),
        .res_vld(res_vld),
        .res(res),
        .overflow(overflow),
        .overflow_sticky(overflow_sticky),
        .ovf_count(ovf_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        num_vectors++;
        if (observed != expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour expressed as plain integer arithmetic.
    task automatic modelStep(input int r, input int v, input int c, input int a);
        int base;
        int s;
        int ov;
        if (r != 0) begin
            m_acc = 0; m_vld = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0;
            return;
        end
        m_vld = v;
        m_ovf = 0;
        base  = m_acc;
        if (c != 0) begin
            m_sticky = 0;
            m_cnt    = 0;
            base     = 0;
            m_acc    = 0;
        end
        if (v != 0) begin
            s  = base + a;
            ov = (s > HALF - 1 || s < -HALF) ? 1 : 0;
            if (ov != 0) begin
`ifdef SIGNED_ACCUM_SATURATE_EN
                s = (s > 0) ? HALF - 1 : -HALF;
`else
                s = (s > 0) ? s - 2 * HALF : s + 2 * HALF;
`endif
                m_sticky = 1;
                if (m_cnt < CMAX) m_cnt++;
            end
            m_acc = s;
            m_ovf = ov;
        end
    endtask

    task automatic applyStimulus(input int r, input int v, input int c, input int a);
        @(negedge clk);
        rst     = (r != 0);
        arg_vld = (v != 0);
        clear   = (c != 0);
        arg     = WIDTH'(a);
        @(posedge clk);
        modelStep(r, v, c, a);
        #1;
        checkOutput("res", int'($signed(res)), m_acc);
        checkOutput("res_vld", int'(res_vld), m_vld);
        checkOutput("overflow", int'(overflow), m_ovf);
        checkOutput("overflow_sticky", int'(overflow_sticky), m_sticky);
        checkOutput("ovf_count", int'(ovf_count), m_cnt);
    endtask

    // Directed scenarios first, then a randomized stream.
    initial begin
        int a;
        int r;
        int c;
        int v;
        rst = 1'b1; arg_vld = 1'b0; clear = 1'b0; arg = '0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 5);
        // 3 then 4, then idle: res_vld pulses exactly twice
        applyStimulus(0, 1, 0, 3);
        applyStimulus(0, 1, 0, 4);
        applyStimulus(0, 0, 0, 0);
        // acc=7, +1 overflows positive
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);
        // acc=-8, -1 overflows negative
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, -8);
        applyStimulus(0, 1, 0, -1);
        // acc=-8, +7 gives -1 without overflow
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, -8);
        applyStimulus(0, 1, 0, 7);
        // repeated overflow drives the counter into saturation
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 7);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 7);
        applyStimulus(0, 1, 0, 1);
        // clear with a valid arg, then clear alone
        applyStimulus(0, 1, 1, 5);
        applyStimulus(0, 0, 1, 0);
        // reset discards a concurrent step, then accumulation restarts from 0
        applyStimulus(0, 1, 0, 5);
        applyStimulus(1, 1, 0, 6);
        applyStimulus(0, 1, 0, 2);

        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(2 * HALF - 1)) - HALF;
            r = ($urandom_range(99) < 2) ? 1 : 0;
            c = ($urandom_range(99) < 6) ? 1 : 0;
            v = ($urandom_range(99) < 75) ? 1 : 0;
            applyStimulus(r, v, c, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
